subtractor_serial: RTL and testbench



---
 rtl/subtractor_serial.sv | 102 ++++++++++
 tb/tb_subtractor_serial.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/subtractor_serial.sv
// Bit-serial W-bit subtractor, LSB first, with valid/ready handshakes on both sides.
// Define SUBTRACTOR_SERIAL_SAT_EN to clamp diff to zero whenever the final borrow is set.
module subtractor_serial #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         bout
);

    localparam int unsigned CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  a_sh_q, b_sh_q, res_q, res_d;
    logic [W-1:0]  diff_q, diff_d;
    logic [CW-1:0] cnt_q;
    logic          br_q, br_d;
    logic          bout_q;
    logic          d_bit;
    logic          last_bit;

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign diff      = diff_q;
    assign bout      = bout_q;

    // Full-subtractor cell on the current LSBs of the operand shifters.
    always_comb begin
        d_bit    = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
        br_d     = (~a_sh_q[0] & b_sh_q[0]) | (~a_sh_q[0] & br_q) | (b_sh_q[0] & br_q);
        res_d    = res_q >> 1;
        res_d[W-1] = d_bit;
        last_bit = (cnt_q == CW'(W - 1));
`ifdef SUBTRACTOR_SERIAL_SAT_EN
        diff_d   = br_d ? '0 : res_d;
`else
        diff_d   = res_d;
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (in_valid) state_d = StBusy;
            StBusy:  if (last_bit) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_sh_q <= a;
                        b_sh_q <= b;
                        br_q   <= bin;
                        cnt_q  <= '0;
                    end
                end
                StBusy: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    res_q  <= res_d;
                    br_q   <= br_d;
                    cnt_q  <= cnt_q + CW'(1);
                    if (last_bit) begin
                        diff_q <= diff_d;
                        bout_q <= br_d;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_subtractor_serial.sv
// Randomised self-checking bench for subtractor_serial (W=3) against an arithmetic model.
// Honours SUBTRACTOR_SERIAL_SAT_EN in the reference model when the build defines it.
module tb_subtractor_serial;

    localparam int unsigned W = 3;
    localparam int unsigned MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;

    int checks = 0;
    int errors = 0;

    subtractor_serial #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer subtraction, borrow is the sign of the true result.
    function automatic logic [W:0] ref_sub(input int ra, input int rb, input int rbin);
        int  r;
        int  d;
        logic bo;
        r  = ra - rb - rbin;
        bo = (r < 0);
        d  = (r + int'(MOD)) % int'(MOD);
`ifdef SUBTRACTOR_SERIAL_SAT_EN
        if (bo) d = 0;
`endif
        return {bo, W'(d)};
    endfunction

    task automatic scramble_inputs();
        a   = W'($urandom);
        b   = W'($urandom);
        bin = 1'($urandom);
    endtask

    // One full transaction; junk=1 keeps in_valid high with changing operands while busy.
    task automatic do_op(input int oa, input int ob, input int obin, input int stall,
                         input bit junk);
        logic [W:0] exp;
        exp = ref_sub(oa, ob, obin);
        check_eq("idle_ready", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        a         = W'(oa);
        b         = W'(ob);
        bin       = 1'(obin);
        out_ready = (stall == 0);
        tick();
        in_valid = junk;
        for (int i = 0; i < int'(W); i++) begin
            check_eq("busy_ready", 32'(in_ready), 32'd0);
            check_eq("busy_valid", 32'(out_valid), 32'd0);
            if (junk) scramble_inputs();
            tick();
        end
        check_eq("done_valid", 32'(out_valid), 32'd1);
        check_eq("diff", 32'(diff), 32'(exp[W-1:0]));
        check_eq("bout", 32'(bout), 32'(exp[W]));
        for (int s = 0; s < stall; s++) begin
            check_eq("stall_ready", 32'(in_ready), 32'd0);
            check_eq("stall_valid", 32'(out_valid), 32'd1);
            check_eq("stall_diff", 32'(diff), 32'(exp[W-1:0]));
            check_eq("stall_bout", 32'(bout), 32'(exp[W]));
            if (junk) scramble_inputs();
            tick();
        end
        out_ready = 1'b1;
        check_eq("hs_valid", 32'(out_valid), 32'd1);
        tick();
        check_eq("post_valid", 32'(out_valid), 32'd0);
        check_eq("post_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_ready", 32'(in_ready), 32'd1);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_diff", 32'(diff), 32'd0);
        check_eq("rst_bout", 32'(bout), 32'd0);

        do_op(5, 3, 0, 0, 1'b0);
        do_op(2, 5, 0, 0, 1'b0);
        do_op(0, 0, 1, 0, 1'b0);
        do_op(7, 7, 0, 0, 1'b0);
        do_op(6, 1, 1, 5, 1'b1);

        // Abort mid-operation; in_valid stays high across the reset edge.
        in_valid = 1'b1;
        a = 3'd3; b = 3'd1; bin = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        check_eq("abort_ready", 32'(in_ready), 32'd1);
        check_eq("abort_valid", 32'(out_valid), 32'd0);
        check_eq("abort_diff", 32'(diff), 32'd0);
        check_eq("abort_bout", 32'(bout), 32'd0);
        for (int i = 0; i < int'(W) + 3; i++) begin
            tick();
            check_eq("abort_no_emit", 32'(out_valid), 32'd0);
        end
        do_op(4, 4, 0, 0, 1'b0);

        // Exhaustive back-to-back with in_valid and out_ready held high.
        for (int v = 0; v < int'(MOD * MOD * 2); v++) begin
            do_op(v % int'(MOD), (v / int'(MOD)) % int'(MOD), v / int'(MOD * MOD), 0, 1'b1);
        end

        // Random operands with random stalls.
        for (int n = 0; n < 40; n++) begin
            do_op(int'($urandom_range(MOD - 1)), int'($urandom_range(MOD - 1)),
                  int'($urandom_range(1)), int'($urandom_range(3)), 1'($urandom));
            for (int g = 0; g < int'($urandom_range(2)); g++) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
